// File: rtl/riscv_pkg.sv
// riscv_pkg: opcodes, field positions and operand-bypass helper shared by the operand fetch stage
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int REG_AW = 5;
  localparam int NREG = 2 ** REG_AW;
  localparam int RD_LSB = 7;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam logic [6:0] OPC_LUI = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP = 7'b0110011;
  typedef struct packed {
    logic uses_rs1;
    logic uses_rs2;
    logic writes_rd;
    logic illegal;
  } src_use_t;
  // x0 reads as zero; a same-cycle writeback beats the stale regfile value
  function automatic logic [XLEN-1:0] fwd(input logic [REG_AW-1:0] r, input logic [XLEN-1:0] rf,
                                          input logic we, input logic [REG_AW-1:0] a3,
                                          input logic [XLEN-1:0] wd);
    return (r == '0) ? '0 : (we && a3 == r) ? wd : rf;
  endfunction
endpackage

// File: rtl/operand_fetch_stage_if.sv
// operand_fetch_stage_if: fetch, regfile, writeback and execute signals of the operand fetch stage
interface operand_fetch_stage_if;
  import riscv_pkg::*;
  logic in_valid, in_ready;
  logic [XLEN-1:0] in_instr, in_pc;
  logic [REG_AW-1:0] rf_a1, rf_a2;
  logic [XLEN-1:0] rf_rd1, rf_rd2;
  logic wb_we;
  logic [REG_AW-1:0] wb_a3;
  logic [XLEN-1:0] wb_wd3;
  logic flush;
  logic out_valid, out_ready;
  logic [XLEN-1:0] out_pc, out_instr, out_op1, out_op2;
  logic [REG_AW-1:0] out_rd;
  logic out_rd_we, out_illegal;
  modport master (
    output in_valid, in_instr, in_pc, rf_rd1, rf_rd2, wb_we, wb_a3, wb_wd3, flush, out_ready,
    input in_ready, rf_a1, rf_a2, out_valid, out_pc, out_instr, out_op1, out_op2, out_rd,
    out_rd_we, out_illegal
  );
  modport slave (
    input in_valid, in_instr, in_pc, rf_rd1, rf_rd2, wb_we, wb_a3, wb_wd3, flush, out_ready,
    output in_ready, rf_a1, rf_a2, out_valid, out_pc, out_instr, out_op1, out_op2, out_rd,
    out_rd_we, out_illegal
  );
endinterface

// File: rtl/rv_src_decode.sv
// rv_src_decode: opcode -> which register fields the instruction reads and writes
module rv_src_decode
  import riscv_pkg::*;
(
  input  logic [6:0] opc,
  output src_use_t   dec
);
  assign dec.writes_rd = opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_OP};
  assign dec.uses_rs1 = opc inside {OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_BRANCH, OPC_STORE, OPC_OP};
  assign dec.uses_rs2 = opc inside {OPC_BRANCH, OPC_STORE, OPC_OP};
  assign dec.illegal = !(dec.writes_rd || dec.uses_rs1);
endmodule

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: regfile read, writeback bypass, busy scoreboard and one-entry output buffer
module operand_fetch_stage
  import riscv_pkg::*;
(
  input logic clk,
  input logic rst_n,
  operand_fetch_stage_if.slave bus
);
  src_use_t dec;
  logic [REG_AW-1:0] rs1, rs2, rd;
  logic [NREG-1:0] sb, busy, set_mask, clr_mask;
  logic hazard, accept, rd_we;
  logic [XLEN-1:0] op1, op2;
  rv_src_decode u_dec (.opc(bus.in_instr[6:0]), .dec(dec));
  assign rs1 = bus.in_instr[RS1_LSB +: REG_AW];
  assign rs2 = bus.in_instr[RS2_LSB +: REG_AW];
  assign rd = bus.in_instr[RD_LSB +: REG_AW];
  assign bus.rf_a1 = rs1;
  assign bus.rf_a2 = rs2;
  assign rd_we = dec.writes_rd && rd != '0;
  assign clr_mask = (bus.wb_we && bus.wb_a3 != '0) ? NREG'(1) << bus.wb_a3 : '0;
  assign set_mask = (accept && rd_we) ? NREG'(1) << rd : '0;
  // a register retiring this very cycle is no longer a hazard; its value comes via the bypass
  assign busy = sb & ~clr_mask;
  assign hazard = (dec.uses_rs1 && busy[rs1]) || (dec.uses_rs2 && busy[rs2]) || (dec.writes_rd && busy[rd]);
  assign bus.in_ready = (!bus.out_valid || bus.out_ready) && !hazard && !bus.flush;
  assign accept = bus.in_valid && bus.in_ready;
  assign op1 = dec.uses_rs1 ? fwd(rs1, bus.rf_rd1, bus.wb_we, bus.wb_a3, bus.wb_wd3) : '0;
  assign op2 = dec.uses_rs2 ? fwd(rs2, bus.rf_rd2, bus.wb_we, bus.wb_a3, bus.wb_wd3) : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb <= '0;
      bus.out_valid <= 1'b0;
      bus.out_pc <= '0;
      bus.out_instr <= '0;
      bus.out_op1 <= '0;
      bus.out_op2 <= '0;
      bus.out_rd <= '0;
      bus.out_rd_we <= 1'b0;
      bus.out_illegal <= 1'b0;
    end else begin
      sb <= bus.flush ? '0 : (sb & ~clr_mask) | set_mask;
      if (accept) begin
        bus.out_valid <= 1'b1;
        bus.out_pc <= bus.in_pc;
        bus.out_instr <= bus.in_instr;
        bus.out_op1 <= op1;
        bus.out_op2 <= op2;
        bus.out_rd <= dec.writes_rd ? rd : '0;
        bus.out_rd_we <= rd_we;
        bus.out_illegal <= dec.illegal;
      end else if (bus.flush || bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule
